// File: rtl/bootprom_if.sv
// bootprom_if: CPU bus and EPROM pair signals seen by the boot PROM sequencer
interface bootprom_if;
  logic        as_n;
  logic        rw;
  logic        uds_n;
  logic        lds_n;
  logic        prom_sel;
  logic [14:0] addr;
  logic [14:0] rom_a;
  logic        rom_ce_n;
  logic        rom_oe_n;
  logic [7:0]  rom_dh;
  logic [7:0]  rom_dl;
  logic [15:0] data_out;
  logic        data_oe;
  logic        dtack_n;
  logic        wr_err;
  modport master (
    output as_n, rw, uds_n, lds_n, prom_sel, addr, rom_dh, rom_dl,
    input  rom_a, rom_ce_n, rom_oe_n, data_out, data_oe, dtack_n, wr_err
  );
  modport slave (
    input  as_n, rw, uds_n, lds_n, prom_sel, addr, rom_dh, rom_dl,
    output rom_a, rom_ce_n, rom_oe_n, data_out, data_oe, dtack_n, wr_err
  );
endinterface

// File: rtl/bootprom_ctl.sv
// bootprom_ctl: sequences CE_n/OE_n/address for the byte-split boot PROM pair and acks the CPU
module bootprom_ctl #(
  parameter int ACCESS_CYCLES = 4,
  parameter bit ABORT_ON_AS   = 1'b1
) (
  input logic       clk,
  input logic       reset_n,
  bootprom_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, ACK} state_t;
  localparam logic [3:0] LOAD = 4'(ACCESS_CYCLES - 1);
  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [14:0] rom_a_d;
  logic [15:0] data_d;
  logic        ce_d, oe_d, data_oe_d, dtack_d, wr_err_d;
  logic        start, abort;
  always_comb begin
    start     = !bus.as_n && bus.prom_sel && (!bus.uds_n || !bus.lds_n);
    abort     = ABORT_ON_AS && bus.as_n;
    state_d   = state;
    cnt_d     = cnt;
    rom_a_d   = bus.rom_a;
    data_d    = bus.data_out;
    ce_d      = bus.rom_ce_n;
    oe_d      = bus.rom_oe_n;
    data_oe_d = bus.data_oe;
    dtack_d   = bus.dtack_n;
    wr_err_d  = 1'b0;
    case (state)
      IDLE: if (start) begin
        // writes never touch the EPROMs; ack anyway so the CPU does not stall
        state_d  = bus.rw ? SETUP : ACK;
        rom_a_d  = bus.rw ? bus.addr : bus.rom_a;
        ce_d     = !bus.rw;
        wr_err_d = !bus.rw;
        dtack_d  = bus.rw;
      end
      SETUP: begin
        state_d = abort ? IDLE : ACCESS;
        ce_d    = abort;
        oe_d    = abort;
        cnt_d   = LOAD;
      end
      ACCESS: begin
        state_d = abort ? IDLE : (cnt == 4'd0 ? CAPTURE : ACCESS);
        ce_d    = abort;
        oe_d    = abort;
        cnt_d   = cnt == 4'd0 ? cnt : cnt - 4'd1;
      end
      CAPTURE: begin
        state_d   = abort ? IDLE : ACK;
        data_d    = abort ? bus.data_out : {bus.rom_dh, bus.rom_dl};
        ce_d      = 1'b1;
        oe_d      = 1'b1;
        data_oe_d = !abort;
        dtack_d   = abort;
      end
      ACK: if (bus.as_n) begin
        state_d   = IDLE;
        dtack_d   = 1'b1;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.rom_a    <= '0;
      bus.rom_ce_n <= 1'b1;
      bus.rom_oe_n <= 1'b1;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
      bus.dtack_n  <= 1'b1;
      bus.wr_err   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bus.rom_a    <= rom_a_d;
      bus.rom_ce_n <= ce_d;
      bus.rom_oe_n <= oe_d;
      bus.data_out <= data_d;
      bus.data_oe  <= data_oe_d;
      bus.dtack_n  <= dtack_d;
      bus.wr_err   <= wr_err_d;
    end
endmodule
